ysyx_22041211_lsu: RTL and testbench
====================================

Name: ysyx_22041211_lsu

Overview:
Multi-cycle load/store unit. It sits directly upstream of the writeback stage and consumes the memory-type instructions issued by the execute/control path. It runs one data-memory transaction over a request/grant/response bus, then aligns and extends load data. It then presents reg_wdata_o with a one-cycle lsu_valid_o pulse, which writeback waits on in its memory-wait state.

Parameters:
DATA_LEN, 32, data/address width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  reset
ctrl_valid_i  in  1  one-cycle pulse: instruction from execute is valid
memory_inst_i  in  1  instruction is a load/store; sampled with ctrl_valid_i
mem_op_i  in  4  {is_store, funct3}; encodings from shared define file
addr_i  in  DATA_LEN  effective address (ALU result)
store_data_i  in  DATA_LEN  rs2 value
mem_req_o  out  1  bus request
mem_we_o  out  1  1 = write
mem_addr_o  out  DATA_LEN  word-aligned address ({addr[31:2],2'b00})
mem_wdata_o  out  DATA_LEN  store data shifted to its byte lane
mem_wmask_o  out  4  byte enables
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  response (load data or store ack)
mem_rdata_i  in  DATA_LEN  load data word
mem_err_i  in  1  bus error, qualified by mem_rvalid_i
reg_wdata_o  out  DATA_LEN  load result for the register file (0 for stores)
lsu_valid_o  out  1  one-cycle done pulse
misalign_o  out  1  valid with lsu_valid_o: address misaligned
fault_o  out  1  valid with lsu_valid_o: bus error

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE. All outputs are 0, including mem_req_o, lsu_valid_o and reg_wdata_o.
- States: IDLE, REQ, RESP, DONE.
- IDLE: on ctrl_valid_i && memory_inst_i, register addr, op and store data. Go to REQ, or to DONE if misaligned.
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - A ctrl_valid_i with memory_inst_i=0 is ignored.
- REQ: mem_req_o=1. mem_we_o, mem_addr_o, mem_wdata_o and mem_wmask_o are held stable until mem_gnt_i.
  - On mem_gnt_i go to RESP; mem_req_o drops the following cycle.
- RESP: wait for mem_rvalid_i. The response is never earlier than the cycle after the grant.
  - On mem_rvalid_i, register the extracted load data into reg_wdata_o (0 for stores) and register mem_err_i into fault_o. Go to DONE.
- DONE: lsu_valid_o=1 for exactly one cycle, then IDLE. reg_wdata_o, misalign_o and fault_o are valid only in this cycle.
- Store lanes, with off = addr[1:0]:
  - SB: mask = 4'b0001<<off.
  - SH: mask = 4'b0011<<off.
  - SW: mask = 4'b1111.
  - wdata = store_data << (8*off).
- Load extraction: byte/half is selected by off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Reserved funct3 behaves as LW.
- Misaligned access: no bus request. misalign_o=1 and lsu_valid_o=1 in DONE, reg_wdata_o=0.
- Minimum latency (grant immediate, response next cycle): ctrl_valid_i at cycle T, mem_req_o at T+1, mem_rvalid_i at T+2, lsu_valid_o at T+3.
- ctrl_valid_i while not IDLE: ignored (upstream never issues while busy).
- mem_rvalid_i outside RESP: discarded.
- rst mid-transaction: immediate return to IDLE, mem_req_o deasserted. A stale response arriving later is discarded by the rule above.

Decomposition:
- Shared define file additions:
  - mem_op encodings: LB=0_000, LH=0_001, LW=0_010, LBU=0_100, LHU=0_101, SB=1_000, SH=1_001, SW=1_010.
  - State encodings (2-bit).
- One natural combinational sub-module, ysyx_22041211_lsu_align: store lane/mask generation and load extract/extend. The FSM and registers stay in the top.

Test Plan:
- LB addr 0x80000003, rdata 0x80FF1234 -> reg_wdata_o 0xFFFFFF80, lsu_valid_o at T+3 with 0-wait grant.
- LHU addr 0x80000002, rdata 0xBEEF0000 -> reg_wdata_o 0x0000BEEF; mem_addr_o 0x80000000, mem_we_o=0.
- SB addr 0x80000001, store_data 0x123456AB -> mem_wmask_o 4'b0010, mem_wdata_o 0x3456AB00, mem_we_o=1; reg_wdata_o 0 in DONE.
- SW addr 0x80000002 -> no mem_req_o ever; lsu_valid_o and misalign_o high at T+1 for one cycle.
- LW with mem_gnt_i low for 3 cycles -> mem_req_o and address held for 4 cycles; later mem_rvalid_i with mem_err_i=1 -> fault_o=1 with lsu_valid_o.
- rst asserted in RESP, then mem_rvalid_i two cycles later -> no lsu_valid_o, outputs remain 0. A following LW completes normally.

Source files
------------

// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared encodings for the load/store unit: memory op codes, FSM states
// and the alignment rule.
package ysyx_22041211_lsu_pkg;

  // mem_op = {is_store, funct3}
  localparam logic [3:0] OpLb  = 4'b0_000;
  localparam logic [3:0] OpLh  = 4'b0_001;
  localparam logic [3:0] OpLw  = 4'b0_010;
  localparam logic [3:0] OpLbu = 4'b0_100;
  localparam logic [3:0] OpLhu = 4'b0_101;
  localparam logic [3:0] OpSb  = 4'b1_000;
  localparam logic [3:0] OpSh  = 4'b1_001;
  localparam logic [3:0] OpSw  = 4'b1_010;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

  // Reserved funct3 values are sized as words, matching their LW load behaviour.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3Byte, F3ByteU: misaligned = 1'b0;
      F3Half, F3HalfU: misaligned = off[0];
      default:         misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Byte-lane steering: store data/mask placement and load extract/extend.
module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic [2:0]          funct3_i,
  input  logic [1:0]          off_i,
  input  logic [DATA_LEN-1:0] store_data_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [3:0]          wmask_o,
  output logic [DATA_LEN-1:0] load_data_o
);

  logic [DATA_LEN-1:0] rshift;

  always_comb begin
    wdata_o = store_data_i << {off_i, 3'b000};
    case (funct3_i)
      F3Byte:  wmask_o = 4'b0001 << off_i;
      F3Half:  wmask_o = 4'b0011 << off_i;
      default: wmask_o = 4'b1111;
    endcase
  end

  always_comb begin
    rshift = rdata_i >> {off_i, 3'b000};
    case (funct3_i)
      F3Byte:  load_data_o = {{(DATA_LEN-8){rshift[7]}}, rshift[7:0]};
      F3Half:  load_data_o = {{(DATA_LEN-16){rshift[15]}}, rshift[15:0]};
      F3ByteU: load_data_o = {{(DATA_LEN-8){1'b0}}, rshift[7:0]};
      F3HalfU: load_data_o = {{(DATA_LEN-16){1'b0}}, rshift[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Multi-cycle load/store unit: one request/grant/response bus transaction per
// memory instruction, then a one-cycle lsu_valid_o pulse towards writeback.
module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctrl_valid_i,
  input  logic                memory_inst_i,
  input  logic [3:0]          mem_op_i,
  input  logic [DATA_LEN-1:0] addr_i,
  input  logic [DATA_LEN-1:0] store_data_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [3:0]          mem_wmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  input  logic                mem_err_i,
  output logic [DATA_LEN-1:0] reg_wdata_o,
  output logic                lsu_valid_o,
  output logic                misalign_o,
  output logic                fault_o
);

  lsu_state_e          state_q;
  logic [DATA_LEN-1:0] addr_q;
  logic [3:0]          op_q;
  logic [DATA_LEN-1:0] store_data_q;
  logic [DATA_LEN-1:0] reg_wdata_q;
  logic                misalign_q;
  logic                fault_q;

  logic [DATA_LEN-1:0] lane_wdata;
  logic [3:0]          lane_wmask;
  logic [DATA_LEN-1:0] load_data;

  ysyx_22041211_lsu_align #(
    .DATA_LEN (DATA_LEN)
  ) u_align (
    .funct3_i     (op_q[2:0]),
    .off_i        (addr_q[1:0]),
    .store_data_i (store_data_q),
    .rdata_i      (mem_rdata_i),
    .wdata_o      (lane_wdata),
    .wmask_o      (lane_wmask),
    .load_data_o  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      op_q         <= '0;
      store_data_q <= '0;
      reg_wdata_q  <= '0;
      misalign_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_valid_i && memory_inst_i) begin
            addr_q       <= addr_i;
            op_q         <= mem_op_i;
            store_data_q <= store_data_i;
            reg_wdata_q  <= '0;
            fault_q      <= 1'b0;
            if (misaligned(mem_op_i[2:0], addr_i[1:0])) begin
              misalign_q <= 1'b1;
              state_q    <= StDone;
            end else begin
              misalign_q <= 1'b0;
              state_q    <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_gnt_i) state_q <= StResp;
        end
        StResp: begin
          if (mem_rvalid_i) begin
            reg_wdata_q <= op_q[3] ? '0 : load_data;
            fault_q     <= mem_err_i;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Results are only meaningful during the done pulse; clear them after.
          reg_wdata_q <= '0;
          misalign_q  <= 1'b0;
          fault_q     <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = (state_q == StReq);
    mem_we_o    = mem_req_o & op_q[3];
    mem_addr_o  = mem_req_o ? {addr_q[DATA_LEN-1:2], 2'b00} : '0;
    mem_wdata_o = mem_we_o ? lane_wdata : '0;
    mem_wmask_o = mem_we_o ? lane_wmask : 4'b0000;
    lsu_valid_o = (state_q == StDone);
    reg_wdata_o = reg_wdata_q;
    misalign_o  = misalign_q;
    fault_o     = fault_q;
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Randomised bench for the LSU against a byte-level behavioural model, with
// directed transactions pinning literal results.
module tb_ysyx_22041211_lsu;
  import ysyx_22041211_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_valid_i, memory_inst_i;
  logic [3:0]  mem_op_i;
  logic [31:0] addr_i, store_data_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] reg_wdata_o;
  logic        lsu_valid_o, misalign_o, fault_o;

  always #5 clk = ~clk;

  ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_valid_i (ctrl_valid_i),
    .memory_inst_i(memory_inst_i),
    .mem_op_i     (mem_op_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .reg_wdata_o  (reg_wdata_o),
    .lsu_valid_o  (lsu_valid_o),
    .misalign_o   (misalign_o),
    .fault_o      (fault_o)
  );

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;

  logic        compare_en = 1'b0;
  logic        exp_req = 1'b0, exp_we = 1'b0, exp_valid = 1'b0, exp_mis = 1'b0, exp_fault = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rw = '0;
  logic [3:0]  exp_mask = '0;

  logic [31:0] last_rw, last_addr, last_wdata;
  logic [3:0]  last_mask;
  logic        last_we, last_mis, last_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (compare_en) begin
      check("mem_req_o", {31'b0, mem_req_o}, {31'b0, exp_req});
      check("lsu_valid_o", {31'b0, lsu_valid_o}, {31'b0, exp_valid});
      if (mem_req_o) req_cycles++;
      if (exp_req) begin
        check("mem_we_o", {31'b0, mem_we_o}, {31'b0, exp_we});
        check("mem_addr_o", mem_addr_o, exp_addr);
        if (exp_we) begin
          check("mem_wdata_o", mem_wdata_o, exp_wdata);
          check("mem_wmask_o", {28'b0, mem_wmask_o}, {28'b0, exp_mask});
        end
        last_we = mem_we_o; last_addr = mem_addr_o;
        last_wdata = mem_wdata_o; last_mask = mem_wmask_o;
      end
      if (exp_valid) begin
        check("reg_wdata_o", reg_wdata_o, exp_rw);
        check("misalign_o", {31'b0, misalign_o}, {31'b0, exp_mis});
        check("fault_o", {31'b0, fault_o}, {31'b0, exp_fault});
        last_rw = reg_wdata_o; last_mis = misalign_o; last_fault = fault_o;
      end
    end
  end

  function automatic int access_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Load result from the byte-level view of the returned word.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] rdata);
    logic [31:0] w, b, h;
    w = rdata >> (8 * off);
    b = w & 32'hFF;
    h = w & 32'hFFFF;
    case (f3)
      3'b000:  return (b ^ 32'h80) - 32'h80;
      3'b001:  return (h ^ 32'h8000) - 32'h8000;
      3'b100:  return b;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_last();
    last_rw = 32'hDEADBEEF; last_addr = 32'hDEADBEEF; last_wdata = 32'hDEADBEEF;
    last_mask = 4'hA; last_we = 1'bx; last_mis = 1'bx; last_fault = 1'bx;
  endtask

  task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                     input logic [31:0] rdata, input int gnt_wait, input int rsp_wait,
                     input logic err);
    logic st;
    int   sz, off;
    st  = op[3];
    sz  = access_size(op[2:0]);
    off = int'(addr[1:0]);
    ctrl_valid_i = 1'b1; memory_inst_i = 1'b1; mem_op_i = op;
    addr_i = addr; store_data_i = sdata;
    exp_req = 1'b0; exp_valid = 1'b0;
    next_cycle();
    ctrl_valid_i = 1'b0; addr_i = $urandom; store_data_i = $urandom; mem_op_i = 4'($urandom);
    if ((int'(addr) % sz) != 0) begin
      exp_valid = 1'b1; exp_rw = '0; exp_mis = 1'b1; exp_fault = 1'b0;
      next_cycle();
      exp_valid = 1'b0;
      return;
    end
    exp_req   = 1'b1;
    exp_we    = st;
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_mask  = 4'(((1 << sz) - 1) << off);
    exp_wdata = sdata << (8 * off);
    for (int i = 0; i <= gnt_wait; i++) begin
      mem_gnt_i    = (i == gnt_wait);
      mem_rvalid_i = 1'($urandom);  // stray responses outside RESP are discarded
      mem_err_i    = 1'($urandom);
      mem_rdata_i  = $urandom;
      ctrl_valid_i = ($urandom_range(0, 3) == 0);
      next_cycle();
    end
    mem_gnt_i = 1'b0; exp_req = 1'b0;
    for (int i = 0; i < rsp_wait; i++) begin
      mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      ctrl_valid_i = ($urandom_range(0, 3) == 0);
      next_cycle();
    end
    ctrl_valid_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
    next_cycle();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = $urandom;
    exp_valid = 1'b1; exp_rw = st ? 32'h0 : model_load(op[2:0], off, rdata);
    exp_mis = 1'b0; exp_fault = err;
    next_cycle();
    exp_valid = 1'b0;
  endtask

  logic [3:0] ops [8];
  int         rc;

  initial begin
    ops = '{OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw};
    rst = 1'b1; ctrl_valid_i = 1'b0; memory_inst_i = 1'b0; mem_op_i = '0;
    addr_i = '0; store_data_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0; mem_err_i = 1'b0;
    next_cycle();
    next_cycle();
    check("reset mem_req_o", {31'b0, mem_req_o}, 32'h0);
    check("reset mem_addr_o", mem_addr_o, 32'h0);
    check("reset mem_wmask_o", {28'b0, mem_wmask_o}, 32'h0);
    check("reset lsu_valid_o", {31'b0, lsu_valid_o}, 32'h0);
    check("reset reg_wdata_o", reg_wdata_o, 32'h0);
    check("reset flags", {30'b0, misalign_o, fault_o}, 32'h0);
    rst = 1'b0;
    compare_en = 1'b1;
    next_cycle();

    clear_last();
    txn(OpLb, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    check("LB result", last_rw, 32'hFFFF_FF80);

    clear_last();
    txn(OpLhu, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 1, 1'b0);
    check("LHU result", last_rw, 32'h0000_BEEF);
    check("LHU addr", last_addr, 32'h8000_0000);
    check("LHU we", {31'b0, last_we}, 32'h0);

    clear_last();
    txn(OpSb, 32'h8000_0001, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 0, 1'b0);
    check("SB mask", {28'b0, last_mask}, 32'h2);
    check("SB wdata", last_wdata, 32'h3456_AB00);
    check("SB we", {31'b0, last_we}, 32'h1);
    check("SB result", last_rw, 32'h0);

    clear_last();
    rc = req_cycles;
    txn(OpSw, 32'h8000_0002, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b0);
    check("SW misalign", {31'b0, last_mis}, 32'h1);
    check("SW no request", rc, req_cycles);

    clear_last();
    rc = req_cycles;
    txn(OpLw, 32'h8000_0010, 32'h0, 32'h0BAD_0BAD, 3, 2, 1'b1);
    check("LW wait req cycles", req_cycles - rc, 4);
    check("LW fault", {31'b0, last_fault}, 32'h1);

    // Reset while waiting for the response; the late response must be ignored.
    ctrl_valid_i = 1'b1; memory_inst_i = 1'b1; mem_op_i = OpLw; addr_i = 32'h8000_0020;
    next_cycle();
    ctrl_valid_i = 1'b0; mem_gnt_i = 1'b1;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h8000_0020;
    next_cycle();
    mem_gnt_i = 1'b0; exp_req = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA_55AA; mem_err_i = 1'b1;
    next_cycle();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("post-reset reg_wdata_o", reg_wdata_o, 32'h0);
      check("post-reset flags", {29'b0, lsu_valid_o, misalign_o, fault_o}, 32'h0);
      next_cycle();
    end
    clear_last();
    txn(OpLw, 32'h8000_0024, 32'h0, 32'h1357_9BDF, 0, 0, 1'b0);
    check("LW after reset", last_rw, 32'h1357_9BDF);

    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          gaps;
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = a & ~32'(access_size(op[2:0]) - 1);
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        ctrl_valid_i = 1'($urandom); memory_inst_i = 1'b0;  // non-memory ops are ignored
        mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
        next_cycle();
      end
      ctrl_valid_i = 1'b0; mem_rvalid_i = 1'b0;
      txn(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0));
    end

    next_cycle();
    compare_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
